tdm_demux_1x4: RTL and testbench

- Receive-side counterpart of the 4:1 lane mux.
- A TX-side sequencer drives the mux select through slots 0..3 and serialises a 4-bit word onto one wire.
- This block recovers that word: it tracks the slot with a counter, steers each bit to its lane, and presents the assembled word with a one-cycle valid strobe.
- It sits directly after the serial link, ahead of the lane consumers.

---
 rtl/tdm_demux_1x4_pkg.sv | 17 +
 rtl/tdm_slot_counter.sv | 44 ++++
 rtl/tdm_demux_1x4.sv | 125 ++++++++++++
 tb/tb_tdm_demux_1x4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1x4_pkg.sv
// Shared constants and types for the TDM lane mux/demux pair.
// Both the TX sequencer and the RX demux import this so slot numbering stays consistent.
package tdm_demux_1x4_pkg;

  localparam int LANES_DEF  = 4;
  localparam int SLOT_W_DEF = 2;
  localparam int FCNT_W_DEF = 8;

  // The slot that must carry frame_sync.
  localparam int SLOT0 = 0;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot tracker for the TDM receiver: wrapping counter with clear and load-to-1.
// Advances only on valid beats; clr has priority over load1, which has priority over inc.
module tdm_slot_counter #(
  parameter int LANES  = 4,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (load1) begin
        cnt_d = SLOT_W'(1);
      end else if (inc) begin
        cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot = cnt_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive-side TDM demux: recovers a LANES-bit word serialised one bit per slot,
// re-locking on frame_sync and flagging framing violations.
module tdm_demux_1x4
  import tdm_demux_1x4_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [LANES-1:0]  data_out,
  output logic              out_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(SLOT0);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(LANES - 1);

  state_e            state_q, state_d;
  logic [LANES-1:0]  shadow_q, shadow_d;
  logic [LANES-1:0]  data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [LANES-1:0]  lane_we;
  logic              cnt_clr, cnt_load1, cnt_inc;
  logic [SLOT_W-1:0] slot_cur;

  tdm_slot_counter #(
    .LANES  (LANES),
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (din_valid),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .slot  (slot_cur)
  );

  // The last-slot bit goes straight to data_out, so only lanes below LANES-1 are ever written here.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    fcnt_d      = fcnt_q;
    lane_we     = '0;
    cnt_clr     = 1'b0;
    cnt_load1   = 1'b0;
    cnt_inc     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            lane_we[SLOT0] = 1'b1;
            cnt_load1      = 1'b1;
            state_d        = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Sync on any slot other than 0 is an early sync: restart the frame on this beat.
            lane_we[SLOT0] = 1'b1;
            cnt_load1      = 1'b1;
            sync_err_d     = (slot_cur != SLOT_FIRST);
          end else if (slot_cur == SLOT_FIRST) begin
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
          end else if (slot_cur == SLOT_LAST) begin
            data_d      = {din, shadow_q[LANES-2:0]};
            out_valid_d = 1'b1;
            fcnt_d      = fcnt_q + FCNT_W'(1);
            cnt_inc     = 1'b1;
          end else begin
            lane_we[slot_cur] = 1'b1;
            cnt_inc           = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_shadow
      assign shadow_d[gi] = lane_we[gi] ? din : shadow_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_cur;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed self-checking bench for tdm_demux_1x4.
module tb_tdm_demux_1x4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] data_out;
  logic       out_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int ov_seen;

  tdm_demux_1x4 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Apply one cycle of inputs; return #1 after the sampling edge.
  task automatic step(input logic r, input logic dv, input logic fs, input logic d);
    rst        = r;
    din_valid  = dv;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) ov_seen++;
  endtask

  task automatic beat(input logic fs, input logic d);
    step(1'b0, 1'b1, fs, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bit k of w is sent in slot k; frame_sync accompanies slot 0.
  task automatic send_frame(input logic [3:0] w);
    beat(1'b1, w[0]);
    beat(1'b0, w[1]);
    beat(1'b0, w[2]);
    beat(1'b0, w[3]);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'h0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
    check({tag, ".slot"}, 32'(slot), 32'h0);
    check({tag, ".locked"}, 32'(locked), 32'h0);
    check({tag, ".sync_err"}, 32'(sync_err), 32'h0);
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'h0);
  endtask

  initial begin
    ov_seen = 0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_cleared("reset");

    // HUNT ignores unsynced beats without error
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    check("hunt.sync_err", 32'(sync_err), 32'h0);
    check("hunt.locked", 32'(locked), 32'h0);
    check("hunt.data_out", 32'(data_out), 32'h0);
    check("hunt.slot", 32'(slot), 32'h0);

    // Clean frame din=1,0,1,0 -> 4'b0101
    ov_seen = 0;
    beat(1'b1, 1'b1);
    check("f1.locked_after_sync", 32'(locked), 32'h1);
    check("f1.slot_after_sync", 32'(slot), 32'h1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    check("f1.out_valid_before_last", 32'(out_valid), 32'h0);
    beat(1'b0, 1'b0);
    check("f1.data_out", 32'(data_out), 32'h5);
    check("f1.out_valid", 32'(out_valid), 32'h1);
    check("f1.frame_cnt", 32'(frame_cnt), 32'h1);
    check("f1.slot", 32'(slot), 32'h0);
    idle();
    check("f1.out_valid_drop", 32'(out_valid), 32'h0);
    check("f1.data_hold", 32'(data_out), 32'h5);
    check("f1.pulses", 32'(ov_seen), 32'h1);

    // Back-to-back: 1010 then 1111 with idles inside
    send_frame(4'b1010);
    check("f2.data_out", 32'(data_out), 32'hA);
    check("f2.out_valid", 32'(out_valid), 32'h1);
    check("f2.frame_cnt", 32'(frame_cnt), 32'h2);
    beat(1'b1, 1'b1);
    check("f3.out_valid_drop", 32'(out_valid), 32'h0);
    beat(1'b0, 1'b1);
    idle();
    check("f3.slot_hold", 32'(slot), 32'h2);
    beat(1'b0, 1'b1);
    idle();
    check("f3.slot_hold2", 32'(slot), 32'h3);
    check("f3.data_hold", 32'(data_out), 32'hA);
    beat(1'b0, 1'b1);
    check("f3.data_out", 32'(data_out), 32'hF);
    check("f3.out_valid", 32'(out_valid), 32'h1);
    check("f3.frame_cnt", 32'(frame_cnt), 32'h3);

    // Early sync on slot 2; restarted frame = 1,1,0,0 -> 4'b0011
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b1);
    check("early.sync_err", 32'(sync_err), 32'h1);
    check("early.out_valid", 32'(out_valid), 32'h0);
    check("early.slot", 32'(slot), 32'h1);
    check("early.locked", 32'(locked), 32'h1);
    beat(1'b0, 1'b1);
    check("early.sync_err_drop", 32'(sync_err), 32'h0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    check("early.data_out", 32'(data_out), 32'h3);
    check("early.out_valid_new", 32'(out_valid), 32'h1);
    check("early.frame_cnt", 32'(frame_cnt), 32'h4);

    // Missing sync at slot 0 while LOCKED
    beat(1'b0, 1'b1);
    check("miss.sync_err", 32'(sync_err), 32'h1);
    check("miss.locked", 32'(locked), 32'h0);
    check("miss.slot", 32'(slot), 32'h0);
    check("miss.data_hold", 32'(data_out), 32'h3);
    check("miss.out_valid", 32'(out_valid), 32'h0);
    idle();
    check("miss.sync_err_drop", 32'(sync_err), 32'h0);

    // frame_cnt wraps after 256 frames from reset
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_cleared("reset2");
    ov_seen = 0;
    for (int i = 0; i < 256; i++) begin
      send_frame(4'((i * 3) & 15));
    end
    check("wrap.frame_cnt", 32'(frame_cnt), 32'h0);
    check("wrap.data_out", 32'(data_out), 32'hD);
    check("wrap.pulses", 32'(ov_seen), 32'd256);

    // Reset mid-frame at slot 2 discards the partial frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    check("rst_mid.slot_before", 32'(slot), 32'h2);
    ov_seen = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_cleared("rst_mid");
    beat(1'b0, 1'b1);
    check("rst_mid.locked_after", 32'(locked), 32'h0);
    check("rst_mid.pulses", 32'(ov_seen), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
